// File: rtl/chess_turn_controller.sv
// -----------------------------------------------------------------------------
// chess_turn_controller
//
// Game sequencer for a two-player chess clock. Decides which player's countdown
// timer runs, reacts to the start, pause and move buttons, and issues load and
// increment pulses to both player timers. A timer overflow ends the game and
// records the winner.
//
// Parameters
//   MOVE_W  width of the full-move counter
//   INC_EN  1 = pulse INC1/INC2 to the player who just moved, 0 = never pulse
//
// Ports
//   CLK        system clock, all state changes on the rising edge
//   CLR        synchronous active-high reset, overrides CE
//   CE         clock enable; inputs are sampled and state advances only when high
//   START      new-game button (level, debounced)
//   PAUSE      pause toggle button (level, debounced)
//   BTN1/BTN2  player move buttons (level, debounced)
//   OVERFLOW1/2 player timer expired (level)
//   EN1/EN2    count enables for the player timers
//   LOAD       one-cycle pulse: both timers reload their initial time
//   INC1/INC2  one-cycle pulse: add the increment to that player's timer
//   TURN       0 = player 1 to move, 1 = player 2 to move
//   END        game over, held until a new game or reset
//   WINNER     01 = player 1 won, 10 = player 2 won, 11 = both flags, 00 = none
//   MOVES      completed full moves, saturating
// -----------------------------------------------------------------------------
module chess_turn_controller #(
    parameter int MOVE_W = 8,
    parameter bit INC_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              CE,
    input  logic              START,
    input  logic              PAUSE,
    input  logic              BTN1,
    input  logic              BTN2,
    input  logic              OVERFLOW1,
    input  logic              OVERFLOW2,
    output logic              EN1,
    output logic              EN2,
    output logic              LOAD,
    output logic              INC1,
    output logic              INC2,
    output logic              TURN,
    output logic              END,
    output logic [1:0]        WINNER,
    output logic [MOVE_W-1:0] MOVES
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN1   = 3'd2,
        S_RUN2   = 3'd3,
        S_PAUSED = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t              state_reg, state_next;
    logic                turn_reg, turn_next;
    logic [MOVE_W-1:0]   moves_reg, moves_next;
    logic [1:0]          winner_reg, winner_next;
    logic                load_reg, load_next;
    logic                inc1_reg, inc1_next;
    logic                inc2_reg, inc2_next;

    // ------------------------------------------------------------------
    // Rising-edge detectors. Bit order: 0 START, 1 PAUSE, 2 BTN1, 3 BTN2.
    // The previous-sample flops reset to 1 so a button held through reset
    // does not produce a spurious edge, and they only advance on CE cycles
    // so edges are seen between consecutive enabled samples.
    // ------------------------------------------------------------------
    logic [3:0] sample;
    logic [3:0] edge_det;

    assign sample = {BTN2, BTN1, PAUSE, START};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_edge
            logic prev_reg;

            always_ff @(posedge CLK) begin
                if (CLR) begin
                    prev_reg <= 1'b1;
                end else if (CE) begin
                    prev_reg <= sample[gi];
                end
            end

            assign edge_det[gi] = CE & sample[gi] & ~prev_reg;
        end
    endgenerate

    logic start_edge, pause_edge, btn1_edge, btn2_edge;
    assign start_edge = edge_det[0];
    assign pause_edge = edge_det[1];
    assign btn1_edge  = edge_det[2];
    assign btn2_edge  = edge_det[3];

    logic overflow;
    logic live;
    assign overflow = OVERFLOW1 | OVERFLOW2;
    // States in which a timer flag can end the game.
    assign live = (state_reg == S_RUN1) || (state_reg == S_RUN2) ||
                  (state_reg == S_PAUSED);

    // ------------------------------------------------------------------
    // State register (also holds the game data and the output pulses)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_reg  <= S_IDLE;
            turn_reg   <= 1'b0;
            moves_reg  <= '0;
            winner_reg <= 2'b00;
            load_reg   <= 1'b0;
            inc1_reg   <= 1'b0;
            inc2_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            turn_reg   <= turn_next;
            moves_reg  <= moves_next;
            winner_reg <= winner_next;
            load_reg   <= load_next;
            inc1_reg   <= inc1_next;
            inc2_reg   <= inc2_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority inside one enabled cycle:
    // overflow > START > PAUSE > move button.
    // Pulse requests default to 0 every cycle, so LOAD/INC last exactly one
    // clock even when CE drops right after the deciding edge.
    // ------------------------------------------------------------------
    always_comb begin
        logic start_game;

        state_next  = state_reg;
        turn_next   = turn_reg;
        moves_next  = moves_reg;
        winner_next = winner_reg;
        load_next   = 1'b0;
        inc1_next   = 1'b0;
        inc2_next   = 1'b0;
        start_game  = 1'b0;

        if (CE) begin
            if (live && overflow) begin
                state_next = S_OVER;
                // A fallen flag loses: OVERFLOW1 alone means player 2 won (10),
                // OVERFLOW2 alone means player 1 won (01).
                winner_next = {OVERFLOW1, OVERFLOW2};
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start_edge) start_game = 1'b1;
                    end
                    S_LOAD: begin
                        state_next = S_RUN1;
                    end
                    S_RUN1: begin
                        if (start_edge) begin
                            start_game = 1'b1;
                        end else if (pause_edge) begin
                            state_next = S_PAUSED;
                        end else if (btn1_edge) begin
                            state_next = S_RUN2;
                            turn_next  = 1'b1;
                            inc1_next  = INC_EN;
                        end
                    end
                    S_RUN2: begin
                        if (start_edge) begin
                            start_game = 1'b1;
                        end else if (pause_edge) begin
                            state_next = S_PAUSED;
                        end else if (btn2_edge) begin
                            state_next = S_RUN1;
                            turn_next  = 1'b0;
                            inc2_next  = INC_EN;
                            // Player 2 completes the full move.
                            if (moves_reg != {MOVE_W{1'b1}}) begin
                                moves_next = moves_reg + MOVE_W'(1);
                            end
                        end
                    end
                    S_PAUSED: begin
                        if (start_edge) begin
                            start_game = 1'b1;
                        end else if (pause_edge) begin
                            state_next = turn_reg ? S_RUN2 : S_RUN1;
                        end
                    end
                    S_OVER: begin
                        if (start_edge) start_game = 1'b1;
                    end
                    default: begin
                        state_next = S_IDLE;
                    end
                endcase
            end

            if (start_game) begin
                state_next  = S_LOAD;
                load_next   = 1'b1;
                turn_next   = 1'b0;
                moves_next  = '0;
                winner_next = 2'b00;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode: enables and END come straight from the registered
    // state, so there is no combinational path from any input.
    // ------------------------------------------------------------------
    always_comb begin
        EN1 = 1'b0;
        EN2 = 1'b0;
        END = 1'b0;
        case (state_reg)
            S_RUN1:  EN1 = 1'b1;
            S_RUN2:  EN2 = 1'b1;
            S_OVER:  END = 1'b1;
            default: ;
        endcase
    end

    assign LOAD   = load_reg;
    assign INC1   = inc1_reg;
    assign INC2   = inc2_reg;
    assign TURN   = turn_reg;
    assign WINNER = winner_reg;
    assign MOVES  = moves_reg;

endmodule

// File: tb/tb_chess_turn_controller.sv
// -----------------------------------------------------------------------------
// tb_chess_turn_controller
//
// Directed testbench for chess_turn_controller, built with a 2-bit move
// counter so saturation is reachable. Each step drives inputs #1 after a
// rising edge, waits for the next edge, and compares the packed outputs
//   {EN1, EN2, LOAD, INC1, INC2, TURN, END, WINNER[1:0], MOVES[1:0]}
// against a hand-computed vector.
// -----------------------------------------------------------------------------
module tb_chess_turn_controller;

    logic       CLK = 1'b0;
    logic       CLR, CE, START, PAUSE, BTN1, BTN2, OVERFLOW1, OVERFLOW2;
    logic       EN1, EN2, LOAD, INC1, INC2, TURN, END;
    logic [1:0] WINNER;
    logic [1:0] MOVES;

    int vectors = 0;
    int errors  = 0;

    chess_turn_controller #(
        .MOVE_W (2),
        .INC_EN (1'b1)
    ) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .CE        (CE),
        .START     (START),
        .PAUSE     (PAUSE),
        .BTN1      (BTN1),
        .BTN2      (BTN2),
        .OVERFLOW1 (OVERFLOW1),
        .OVERFLOW2 (OVERFLOW2),
        .EN1       (EN1),
        .EN2       (EN2),
        .LOAD      (LOAD),
        .INC1      (INC1),
        .INC2      (INC2),
        .TURN      (TURN),
        .END       (END),
        .WINNER    (WINNER),
        .MOVES     (MOVES)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Field order: en1 en2 load inc1 inc2 turn end | winner | moves
    task automatic chk(input string tag, input logic [10:0] expected);
        logic [10:0] observed;
        observed = {EN1, EN2, LOAD, INC1, INC2, TURN, END, WINNER, MOVES};
        vectors++;
        assert (observed === expected)
            $display("vector %0d %s: outputs %b ok", vectors, tag, observed);
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        logic [1:0] mv_exp;

        CLR = 1'b1; CE = 1'b1; START = 1'b0; PAUSE = 1'b0;
        BTN1 = 1'b1; BTN2 = 1'b0; OVERFLOW1 = 1'b0; OVERFLOW2 = 1'b0;
        #1;
        tick(); tick();
        chk("reset",            11'b0_0_0_0_0_0_0_00_00);

        // BTN1 held through reset must not fire; a fresh edge in IDLE is ignored
        CLR = 1'b0; tick();
        chk("idle_held_btn1",   11'b0_0_0_0_0_0_0_00_00);
        BTN1 = 1'b0; tick();
        BTN1 = 1'b1; tick();
        chk("idle_btn1_edge",   11'b0_0_0_0_0_0_0_00_00);
        BTN1 = 1'b0; tick();

        // Start a game
        START = 1'b1; tick();
        chk("load_pulse",       11'b0_0_1_0_0_0_0_00_00);
        START = 1'b0; tick();
        chk("run1",             11'b1_0_0_0_0_0_0_00_00);

        // BTN2 ignored in RUN1
        BTN2 = 1'b1; tick();
        chk("run1_btn2_ignored",11'b1_0_0_0_0_0_0_00_00);
        BTN2 = 1'b0; tick();

        // Player 1 moves
        BTN1 = 1'b1; tick();
        chk("p1_move",          11'b0_1_0_1_0_1_0_00_00);
        BTN1 = 1'b0; tick();
        chk("inc1_cleared",     11'b0_1_0_0_0_1_0_00_00);

        // Player 2 moves: one full move done
        BTN2 = 1'b1; tick();
        chk("p2_move",          11'b1_0_0_0_1_0_0_00_01);
        BTN2 = 1'b0; tick();

        BTN1 = 1'b1; tick();
        chk("p1_move_2",        11'b0_1_0_1_0_1_0_00_01);
        BTN1 = 1'b0; tick();

        // Pause in RUN2, move buttons ignored, resume to RUN2
        PAUSE = 1'b1; tick();
        chk("paused",           11'b0_0_0_0_0_1_0_00_01);
        PAUSE = 1'b0; tick();
        BTN1 = 1'b1; BTN2 = 1'b1; tick();
        chk("paused_btns",      11'b0_0_0_0_0_1_0_00_01);
        BTN1 = 1'b0; BTN2 = 1'b0; tick();
        PAUSE = 1'b1; tick();
        chk("resume_run2",      11'b0_1_0_0_0_1_0_00_01);
        PAUSE = 1'b0; tick();

        // Player 2 flag falls: player 1 wins, state frozen
        OVERFLOW2 = 1'b1; tick();
        chk("ovf2_over",        11'b0_0_0_0_0_1_1_01_01);
        OVERFLOW2 = 1'b0; tick();
        chk("over_held",        11'b0_0_0_0_0_1_1_01_01);
        BTN2 = 1'b1; PAUSE = 1'b1; tick();
        chk("over_btns",        11'b0_0_0_0_0_1_1_01_01);
        BTN2 = 1'b0; PAUSE = 1'b0; tick();

        // New game from OVER
        START = 1'b1; tick();
        chk("restart_load",     11'b0_0_1_0_0_0_0_00_00);
        START = 1'b0; tick();
        chk("restart_run1",     11'b1_0_0_0_0_0_0_00_00);

        // Both flags together
        OVERFLOW1 = 1'b1; OVERFLOW2 = 1'b1; tick();
        chk("both_flags",       11'b0_0_0_0_0_0_1_11_00);
        OVERFLOW1 = 1'b0; OVERFLOW2 = 1'b0;
        START = 1'b1; tick();
        START = 1'b0; tick();

        // Overflow beats a move button: no INC1, TURN unchanged
        OVERFLOW1 = 1'b1; BTN1 = 1'b1; tick();
        chk("ovf1_vs_btn1",     11'b0_0_0_0_0_0_1_10_00);
        OVERFLOW1 = 1'b0; BTN1 = 1'b0; tick();

        // Four full moves with a 2-bit counter saturate at 3
        START = 1'b1; tick();
        START = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            BTN1 = 1'b1; tick();
            BTN1 = 1'b0; tick();
            BTN2 = 1'b1; tick();
            mv_exp = (i < 2) ? 2'(i + 1) : 2'd3;
            chk("full_move", {7'b1_0_0_0_1_0_0, 2'b00, mv_exp});
            BTN2 = 1'b0; tick();
        end

        // Into RUN2, then CE low blocks a BTN2 edge
        BTN1 = 1'b1; tick();
        BTN1 = 1'b0; tick();
        chk("run2_sat",         11'b0_1_0_0_0_1_0_00_11);
        CE = 1'b0; BTN2 = 1'b1; tick();
        chk("ce_low_hold",      11'b0_1_0_0_0_1_0_00_11);

        // CLR with CE low, mid-RUN2
        CLR = 1'b1; tick();
        chk("clr_mid_run2",     11'b0_0_0_0_0_0_0_00_00);

        // LOAD pulse is one clock even when CE drops right after the START edge
        CLR = 1'b0; CE = 1'b1; BTN2 = 1'b0; tick();
        START = 1'b1; tick();
        chk("load_ce",          11'b0_0_1_0_0_0_0_00_00);
        CE = 1'b0; tick();
        chk("load_one_clk",     11'b0_0_0_0_0_0_0_00_00);
        CE = 1'b1; tick();
        chk("load_to_run1",     11'b1_0_0_0_0_0_0_00_00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/chess_turn_controller.md
# chess_turn_controller

Game sequencer for the chess clock. Decides which player's countdown timer runs, handles the start, pause and move-button inputs, and issues load and increment pulses to both timers. It absorbs the overflow-to-END latching and adds the winner decision. It sits between the debounced front-panel inputs and the two player timer datapaths.

## Interface
- MOVE_W, 8: width of the full-move counter
- INC_EN, 1: 1 = issue a Fischer increment pulse to the player who just moved; 0 = never pulse INC1/INC2

- CLK  in  1  system clock; all state changes on the rising edge
- CLR  in  1  reset, synchronous, active-high
- CE  in  1  clock enable; when low, state, counter and edge-detect registers hold
- START  in  1  debounced start / new-game button (level)
- PAUSE  in  1  debounced pause toggle button (level)
- BTN1  in  1  debounced player-1 move button (level)
- BTN2  in  1  debounced player-2 move button (level)
- OVERFLOW1  in  1  player-1 timer expired (level)
- OVERFLOW2  in  1  player-2 timer expired (level)
- EN1  out  1  count enable, player-1 timer
- EN2  out  1  count enable, player-2 timer
- LOAD  out  1  one-CLK pulse: both timers reload their initial time
- INC1  out  1  one-CLK pulse: add the increment to the player-1 timer
- INC2  out  1  one-CLK pulse: add the increment to the player-2 timer
- TURN  out  1  0 = player 1 to move, 1 = player 2 to move
- END  out  1  game over, held high until a new game or reset
- WINNER  out  2  2'b01 = player 1 won, 2'b10 = player 2 won, 2'b11 = both flags fell, 2'b00 = no result
- MOVES  out  MOVE_W  completed full moves, saturating

## Operation
- Inputs are sampled only on CE cycles.
- A rising edge on an input means: the previous-sample register is 0 and the current sample is 1.
- Previous-sample registers reset to 1, so a button held through reset does not fire.
- States: IDLE, LOAD, RUN1, RUN2, PAUSED, OVER.
- IDLE:
  - START edge -> LOAD.
  - All other inputs are ignored, including overflows.
- LOAD:
  - Asserts the LOAD pulse.
  - Clears MOVES and WINNER, and sets TURN=0.
  - Next CE cycle -> RUN1 (player 1 starts).
  - Overflows are ignored.
- RUN1: EN1=1.
  - BTN1 edge -> RUN2, TURN=1, INC1 pulse (if INC_EN=1).
  - BTN2 is ignored.
- RUN2: EN2=1.
  - BTN2 edge -> RUN1, TURN=0, INC2 pulse (if INC_EN=1).
  - MOVES increments by 1 and saturates at all-ones.
  - BTN1 is ignored.
- PAUSE edge in RUN1 or RUN2 -> PAUSED; TURN is kept.
- PAUSED:
  - EN1=EN2=0; move buttons are ignored.
  - PAUSE edge -> RUN1 if TURN=0, RUN2 if TURN=1.
- OVERFLOW1 or OVERFLOW2 high in RUN1, RUN2 or PAUSED -> OVER.
  - WINNER = {OVERFLOW1, OVERFLOW2} mapped as: OVERFLOW1 only -> 2'b10; OVERFLOW2 only -> 2'b01; both -> 2'b11.
- OVER:
  - END=1, EN1=EN2=0.
  - WINNER, MOVES and TURN are frozen.
  - Buttons and PAUSE are ignored.
- START edge in RUN1, RUN2, PAUSED or OVER -> LOAD (new game); END drops on entry to LOAD.
- Priority within one CE cycle: CLR > overflow > START > PAUSE > move button.
  - Example: an overflow and BTN1 together in RUN1 -> OVER, no INC1, TURN unchanged.
- EN1, EN2 and END are decoded from the registered state: glitch-free, no combinational path from inputs.

## Timing
- Reset (CLR high at a CLK edge):
  - State = IDLE.
  - EN1=EN2=LOAD=INC1=INC2=TURN=END=0, WINNER=2'b00, MOVES=0.
  - Previous-sample registers = 1.
  - CLR overrides CE, and acts mid-game in any state.
- Latency: an input edge sampled on CE cycle n updates state, TURN, MOVES and the outputs at the CLK edge ending cycle n.
- LOAD, INC1 and INC2:
  - High for exactly one CLK cycle: the cycle after the deciding edge, regardless of CE.
  - Cleared on every CLK cycle in which they are not set.
- CE low for any number of cycles: no state change and no pulses; edges are detected only between consecutive CE samples.
- A button held high gives one edge only; it must return low for at least one CE sample to re-arm.

## Test plan
- Reset with BTN1=1 held, then CE=1 continuously:
  - all outputs 0, state IDLE;
  - releasing and re-pressing BTN1 in IDLE has no effect.
- START edge:
  - LOAD pulses for 1 CLK;
  - the next CE cycle gives EN1=1, TURN=0;
  - BTN1 edge -> EN1=0, EN2=1, TURN=1, INC1 pulse;
  - BTN2 edge -> MOVES=1, INC2 pulse.
- Ignored-button checks:
  - in RUN1, a BTN2 edge -> no change;
  - in PAUSED, BTN1/BTN2 edges -> no change;
  - a second PAUSE edge resumes with the saved TURN=1 -> EN2=1.
- OVERFLOW2 pulse while in RUN2 -> END=1, WINNER=2'b01, EN1=EN2=0; state held until a START edge, which gives LOAD, END=0, MOVES=0.
- Simultaneous events:
  - OVERFLOW1 and OVERFLOW2 together -> WINNER=2'b11;
  - OVERFLOW1 and BTN1 edge in the same CE cycle -> OVER, no INC1 pulse.
- Saturation and reset:
  - MOVE_W=2: four full moves -> MOVES saturates at 3;
  - CLR asserted mid-RUN2 with CE=0 -> all outputs return to reset values on the next CLK edge.
